wbm_regs_mc: RTL and testbench
==============================

Name: wbm_regs_mc

Overview:
- Parametrised multi-channel successor to the DMA engine's Wishbone slave control/status register file; sits between the host Wishbone bus and NCH DMA channel controllers.
- Provides per-channel CCR/NDAR/status registers plus global ID, sticky interrupt-pending (W1C), interrupt-mask and system-control registers.
- Registered single-wait-state ack, error response on illegal access, byte-lane writes and an aggregated interrupt line.

Parameters:
- NCH, 4, number of DMA channels, 1..16.
- VERSION, 8'h02, returned in ID register bits [15:8].

Ports:
- wb_clk_i  in  1  Wishbone/system clock.
- wb_rst_n_i  in  1  synchronous active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave strobes.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data, registered.
- wbs_ack_o, wbs_err_o, wbs_rty_o  out  1 each  termination; rty tied 0.
- ch_dar_i  in  NCH*32  current descriptor address per channel.
- ch_dc_i  in  NCH*24  remaining byte count per channel.
- ch_busy_i, ch_int_i  in  NCH  channel busy / interrupt level.
- ndar_dirty_clear_i, append_clear_i  in  NCH  per-channel clear pulses from the DMA.
- enable_o, append_o, ndar_dirty_o, int_enable_o  out  NCH  per-channel control.
- int_clear_o  out  NCH  one-cycle pulse per channel.
- ndar_o  out  NCH*29  next descriptor address [31:3] per channel.
- irq_o  out  1  aggregated interrupt, registered.
- sys_rst_o  out  1  = !wb_rst_n_i | sysctl_rst.

Behaviour:
- Address decode: adr[10]=1 selects the block; adr[10]=0 gives an err response.
  - adr[9]=0 selects global register adr[4:2].
  - adr[9]=1 selects channel adr[8:5], register adr[4:2].
- Channel registers:
  - 0 CCR RW: b0 append, b1 enable, b2 int_clear (write-1 pulse, reads 0), b30 int_enable.
  - 1 CSR RO: {busy, int}.
  - 2 DAR RO.
  - 3 NDAR RW, {ndar, 3'b0}.
  - 4 DC RO, zero-extended.
  - 5-7 read 0, writes ignored, ack.
- Global registers:
  - 0 ID RO: {16'hAA55, VERSION, NCH[7:0]}.
  - 1 PEND: RO read, W1C write.
  - 2 MASK RW.
  - 3 SYSCTL RW: b31 sys_rst.
  - 4-7 err.
- Handshake FSM:
  - IDLE: cyc&stb -> RESP.
  - RESP: assert exactly one of ack/err for one cycle with wbs_dat_o valid; -> IDLE unconditionally.
  - Ack/err is never asserted two consecutive cycles; back-to-back accesses take 2 cycles each.
- Writes commit on the IDLE->RESP edge. A register's field updates only if the byte lane containing it has sel set.
- Err cases, with no state change:
  - channel index >= NCH;
  - global offset 4-7;
  - adr[10]=0;
  - NDAR write while that channel's enable=1.
- wbs_dat_o = 0 on err.
- ndar_dirty: set by a legal NDAR write, cleared by ndar_dirty_clear_i; simultaneous set and clear -> set wins.
- append: CCR write loads b0, otherwise append_clear_i clears it; simultaneous -> CCR write wins.
- PEND[c]: set on a ch_int_i rising edge (edge detect from a registered copy, so set is 1 cycle after the rise). A W1C write clears; simultaneous set and clear -> set wins.
- irq_o = registered |(PEND & MASK); it rises 1 cycle after PEND sets.
- Reset (wb_rst_n_i=0 at an edge) has priority over everything. Cleared to 0: state IDLE, ack, err, dat_o, enable, append, ndar_dirty, int_enable, int_clear, PEND, MASK, sysctl_rst, edge-detect registers. Not reset: ndar_o.
- A reset asserted in RESP drops ack the next cycle; a write arriving on the reset edge is discarded.

Test Plan:
- Read global 0 with NCH=4, VERSION=2 -> one cycle after stb, ack=1, dat=32'hAA55_0204; next cycle ack=0.
- Ch2 NDAR write 32'h1234_5678, sel=4'hF, enable=0 -> ndar_o[ch2]=29'h0246_8ACF, ndar_dirty_o[2]=1. Same write with enable=1 -> err=1, ndar unchanged. ndar_dirty_clear_i[2] coincident with a legal write -> dirty stays 1.
- Ch0 CCR write 32'h4000_0007 -> enable=1, append=1, int_enable=1, int_clear_o[0] high exactly 1 cycle. append_clear_i[0] pulse -> append=0.
- ch_int_i[1] 0->1 with MASK=4'h2 -> PEND=4'h2 next cycle, irq_o=1 the cycle after. W1C 32'h2 on the same cycle as a new rise -> PEND stays 4'h2. A later clean W1C -> PEND=0, irq_o=0.
- Channel 5 access with NCH=4, global offset 6, and adr[10]=0 -> each gives err=1, ack=0, dat=0, no state change.
- sel=4'h1 write 32'hFFFF_FFFF to SYSCTL -> sys_rst_o stays 0. sel=4'h8 -> sys_rst_o=1. wb_rst_n_i=0 while in RESP -> ack=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/wbm_regs_mc_if.sv
// Wishbone classic slave bundle for the multi-channel DMA register block.
// Member names follow the host bus pin names; modports give each side's view.
interface wbm_regs_mc_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        wbs_err_o;
   logic        wbs_rty_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
   );
endinterface

// File: rtl/wbm_regs_mc.sv
// Wishbone control/status register file for NCH DMA channels: per-channel CCR/NDAR/
// status, global ID / sticky pending / mask / system control, single-wait-state ack.
module wbm_regs_mc #(
   parameter int         NCH     = 4,
   parameter logic [7:0] VERSION = 8'h02
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   wbm_regs_mc_if.slave        wbs,
   input  logic [NCH*32-1:0]   ch_dar_i,
   input  logic [NCH*24-1:0]   ch_dc_i,
   input  logic [NCH-1:0]      ch_busy_i,
   input  logic [NCH-1:0]      ch_int_i,
   input  logic [NCH-1:0]      ndar_dirty_clear_i,
   input  logic [NCH-1:0]      append_clear_i,
   output logic [NCH-1:0]      enable_o,
   output logic [NCH-1:0]      append_o,
   output logic [NCH-1:0]      ndar_dirty_o,
   output logic [NCH-1:0]      int_enable_o,
   output logic [NCH-1:0]      int_clear_o,
   output logic [NCH*29-1:0]   ndar_o,
   output logic                irq_o,
   output logic                sys_rst_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   localparam logic [2:0] CH_CCR  = 3'd0;
   localparam logic [2:0] CH_CSR  = 3'd1;
   localparam logic [2:0] CH_DAR  = 3'd2;
   localparam logic [2:0] CH_NDAR = 3'd3;
   localparam logic [2:0] CH_DC   = 3'd4;

   localparam logic [2:0] GL_ID     = 3'd0;
   localparam logic [2:0] GL_PEND   = 3'd1;
   localparam logic [2:0] GL_MASK   = 3'd2;
   localparam logic [2:0] GL_SYSCTL = 3'd3;

   logic [0:0]     state;
   logic           ack_q;
   logic           err_q;
   logic [31:0]    dat_q;

   logic [NCH-1:0] pend;
   logic [NCH-1:0] mask;
   logic [NCH-1:0] int_q;
   logic           sysctl_rst;

   logic [2:0]     reg_sel;
   logic [3:0]     ch_sel;
   logic           in_blk;
   logic           is_ch;
   logic           start;
   logic           acc_err;
   logic           wr_ok;
   logic [31:0]    wdat;
   logic [31:0]    wmask;
   logic [31:0]    rd_data;
   logic [NCH-1:0] ch_hit;
   logic [NCH-1:0] ccr_wr;
   logic [NCH-1:0] ndar_wr;
   logic [NCH-1:0] pend_clr;
   logic [NCH-1:0] int_rise;
   logic           pend_wr;
   logic           mask_wr;
   logic           sysctl_wr;
   logic           unused_adr;

   assign reg_sel    = wbs.wbs_adr_i[4:2];
   assign ch_sel     = wbs.wbs_adr_i[8:5];
   assign is_ch      = wbs.wbs_adr_i[9];
   assign in_blk     = wbs.wbs_adr_i[10];
   assign unused_adr = ^{wbs.wbs_adr_i[31:11], wbs.wbs_adr_i[1:0]};
   assign wdat       = wbs.wbs_dat_i;
   assign wmask      = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                        {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

   assign start = (state == ST_IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i;

   always_comb begin
      // NOTE: every always_comb output is given a default before any branch, so no
      // path can leave it holding its previous value and infer a latch.
      ch_hit = '0;
      for (int c = 0; c < NCH; c++)
         ch_hit[c] = in_blk && is_ch && (ch_sel == 4'(c));
   end

   // A locked NDAR (channel running) is refused rather than silently ignored.
   assign acc_err = !in_blk
                 || (!is_ch && reg_sel[2])
                 || (is_ch && !(|ch_hit))
                 || (wbs.wbs_we_i && (reg_sel == CH_NDAR) && (|(ch_hit & enable_o)));

   assign wr_ok     = start && wbs.wbs_we_i && !acc_err;
   assign pend_wr   = wr_ok && !is_ch && (reg_sel == GL_PEND);
   assign mask_wr   = wr_ok && !is_ch && (reg_sel == GL_MASK);
   assign sysctl_wr = wr_ok && !is_ch && (reg_sel == GL_SYSCTL);

   always_comb begin
      ccr_wr  = '0;
      ndar_wr = '0;
      for (int c = 0; c < NCH; c++) begin
         ccr_wr[c]  = wr_ok && ch_hit[c] && (reg_sel == CH_CCR);
         ndar_wr[c] = wr_ok && ch_hit[c] && (reg_sel == CH_NDAR);
      end
   end

   assign pend_clr = pend_wr ? (wdat[NCH-1:0] & wmask[NCH-1:0]) : '0;
   assign int_rise = ch_int_i & ~int_q;

   always_comb begin
      rd_data = '0;
      if (!is_ch) begin
         case (reg_sel)
            GL_ID:     rd_data = {16'hAA55, VERSION, 8'(NCH)};
            GL_PEND:   rd_data[NCH-1:0] = pend;
            GL_MASK:   rd_data[NCH-1:0] = mask;
            GL_SYSCTL: rd_data[31] = sysctl_rst;
            default:   rd_data = '0;
         endcase
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ch_hit[c]) begin
               case (reg_sel)
                  CH_CCR:  rd_data = {1'b0, int_enable_o[c], 27'b0, 1'b0,
                                      enable_o[c], append_o[c]};
                  CH_CSR:  rd_data = {30'b0, ch_busy_i[c], ch_int_i[c]};
                  CH_DAR:  rd_data = ch_dar_i[c*32 +: 32];
                  CH_NDAR: rd_data = {ndar_o[c*29 +: 29], 3'b000};
                  CH_DC:   rd_data = {8'b0, ch_dc_i[c*24 +: 24]};
                  default: rd_data = '0;
               endcase
            end
         end
      end
   end

   // Handshake: one IDLE cycle to sample, one RESP cycle with ack or err.
   always_ff @(posedge wb_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!wb_rst_n_i) begin
         state <= ST_IDLE;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               if (start) begin
                  state <= ST_RESP;
                  ack_q <= !acc_err;
                  err_q <= acc_err;
                  dat_q <= acc_err ? 32'h0 : rd_data;
               end
            end
            default: begin
               state <= ST_IDLE;
               ack_q <= 1'b0;
               err_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         enable_o     <= '0;
         append_o     <= '0;
         ndar_dirty_o <= '0;
         int_enable_o <= '0;
         int_clear_o  <= '0;
         pend         <= '0;
         mask         <= '0;
         int_q        <= '0;
         sysctl_rst   <= 1'b0;
         irq_o        <= 1'b0;
      end else begin
         int_q <= ch_int_i;
         // New edges win over a coincident W1C so no interrupt is lost.
         pend  <= (pend & ~pend_clr) | int_rise;
         irq_o <= |(pend & mask);
         if (mask_wr)
            mask <= (mask & ~wmask[NCH-1:0]) | (wdat[NCH-1:0] & wmask[NCH-1:0]);
         if (sysctl_wr && wbs.wbs_sel_i[3])
            sysctl_rst <= wdat[31];
         for (int c = 0; c < NCH; c++) begin
            int_clear_o[c] <= ccr_wr[c] && wbs.wbs_sel_i[0] && wdat[2];
            if (ccr_wr[c] && wbs.wbs_sel_i[0]) begin
               append_o[c] <= wdat[0];
               enable_o[c] <= wdat[1];
            end else if (append_clear_i[c]) begin
               append_o[c] <= 1'b0;
            end
            if (ccr_wr[c] && wbs.wbs_sel_i[3])
               int_enable_o[c] <= wdat[30];
            if (ndar_wr[c])
               ndar_dirty_o[c] <= 1'b1;
            else if (ndar_dirty_clear_i[c])
               ndar_dirty_o[c] <= 1'b0;
         end
      end
   end

   // NOTE: the descriptor address is pure data behind ndar_dirty, so it carries no
   // reset; a write landing on a reset edge must still be dropped.
   always_ff @(posedge wb_clk_i) begin
      for (int c = 0; c < NCH; c++) begin
         if (wb_rst_n_i && ndar_wr[c])
            ndar_o[c*29 +: 29] <= (ndar_o[c*29 +: 29] & ~wmask[31:3])
                                | (wdat[31:3] & wmask[31:3]);
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_err_o = err_q;
   assign wbs.wbs_dat_o = dat_q;
   assign wbs.wbs_rty_o = 1'b0;
   assign sys_rst_o     = !wb_rst_n_i || sysctl_rst;

endmodule

// File: tb/tb_wbm_regs_mc.sv
// Directed bench for wbm_regs_mc: bus tasks push expected responses into a
// scoreboard queue; a negedge monitor pops and compares each ack/err it sees.
module tb_wbm_regs_mc;
   localparam int NCH = 4;

   typedef struct {
      logic        err;
      logic [31:0] dat;
      logic        chk;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NCH*32-1:0]  ch_dar;
   logic [NCH*24-1:0]  ch_dc;
   logic [NCH-1:0]     ch_busy;
   logic [NCH-1:0]     ch_int;
   logic [NCH-1:0]     dirty_clr;
   logic [NCH-1:0]     append_clr;
   logic [NCH-1:0]     enable;
   logic [NCH-1:0]     append;
   logic [NCH-1:0]     ndar_dirty;
   logic [NCH-1:0]     int_enable;
   logic [NCH-1:0]     int_clear;
   logic [NCH*29-1:0]  ndar;
   logic               irq;
   logic               sys_rst;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic prev_resp = 1'b0;

   wbm_regs_mc_if bus();

   wbm_regs_mc #(.NCH(NCH), .VERSION(8'h02)) dut (
      .wb_clk_i           (clk),
      .wb_rst_n_i         (rst_n),
      .wbs                (bus),
      .ch_dar_i           (ch_dar),
      .ch_dc_i            (ch_dc),
      .ch_busy_i          (ch_busy),
      .ch_int_i           (ch_int),
      .ndar_dirty_clear_i (dirty_clr),
      .append_clear_i     (append_clr),
      .enable_o           (enable),
      .append_o           (append),
      .ndar_dirty_o       (ndar_dirty),
      .int_enable_o       (int_enable),
      .int_clear_o        (int_clear),
      .ndar_o             (ndar),
      .irq_o              (irq),
      .sys_rst_o          (sys_rst)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor: every ack/err must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.wbs_ack_o || bus.wbs_err_o) begin
         check("no_back_to_back_resp", {31'b0, prev_resp}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_resp", {30'b0, bus.wbs_ack_o, bus.wbs_err_o}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("resp_err", {31'b0, bus.wbs_err_o}, {31'b0, mon_e.err});
            check("resp_ack", {31'b0, bus.wbs_ack_o}, {31'b0, !mon_e.err});
            if (mon_e.chk)
               check("resp_dat", bus.wbs_dat_o, mon_e.dat);
         end
         prev_resp = 1'b1;
      end else begin
         prev_resp = 1'b0;
      end
   end

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wdat, input logic exp_err,
                       input logic [31:0] exp_dat, input logic chk);
      logic seen;
      exp_t e;
      seen = 1'b0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_sel_i = sel;
      bus.wbs_dat_i = wdat;
      e.err = exp_err;
      e.dat = exp_dat;
      e.chk = chk;
      sb.push_back(e);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.wbs_ack_o || bus.wbs_err_o) begin
            seen = 1'b1;
            break;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      if (!seen) begin
         check("resp_timeout", {31'b0, seen}, 32'd1);
         if (sb.size() > 0)
            e = sb.pop_back();
      end
   endtask

   task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d);
      xfer(1'b1, adr, sel, d, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic wr_err(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d);
      xfer(1'b1, adr, sel, d, 1'b1, 32'h0, 1'b1);
   endtask

   task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
      xfer(1'b0, adr, 4'hF, 32'h0, 1'b0, exp, 1'b1);
   endtask

   task automatic rd_err(input logic [31:0] adr);
      xfer(1'b0, adr, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
   endtask

   task automatic pulse_dirty_clr(input logic [NCH-1:0] v);
      @(negedge clk);
      dirty_clr = v;
      @(negedge clk);
      dirty_clr = '0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
      ch_dar        = {32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      ch_dc         = {24'hAB_CDEF, 24'h11_1111, 24'h22_2222, 24'h33_3333};
      ch_busy       = 4'b1000;
      ch_int        = '0;
      dirty_clr     = '0;
      append_clr    = '0;

      repeat (3) @(negedge clk);
      check("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
      check("rst_err", {31'b0, bus.wbs_err_o}, 32'd0);
      check("rst_rty", {31'b0, bus.wbs_rty_o}, 32'd0);
      check("rst_dat", bus.wbs_dat_o, 32'h0);
      check("rst_enable", {28'b0, enable}, 32'h0);
      check("rst_dirty", {28'b0, ndar_dirty}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_sys_rst_in_reset", {31'b0, sys_rst}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("sys_rst_after_release", {31'b0, sys_rst}, 32'd0);

      // ID register and single-cycle ack.
      rd(32'h400, 32'hAA55_0204);
      @(negedge clk);
      check("ack_drops", {31'b0, bus.wbs_ack_o}, 32'd0);

      // Channel 2 NDAR: write, readback, dirty handling, lock while enabled.
      wr(32'h64C, 4'hF, 32'h1234_5678);
      check("ndar2_value", {3'b0, ndar[2*29 +: 29]}, 32'h0246_8ACF);
      check("ndar2_dirty_set", {28'b0, ndar_dirty}, 32'h4);
      rd(32'h64C, 32'h1234_5678);
      pulse_dirty_clr(4'b0100);
      check("ndar2_dirty_cleared", {28'b0, ndar_dirty}, 32'h0);
      fork
         wr(32'h64C, 4'hF, 32'h0000_1000);
         pulse_dirty_clr(4'b0100);
      join
      check("dirty_set_wins", {28'b0, ndar_dirty}, 32'h4);
      check("ndar2_second", {3'b0, ndar[2*29 +: 29]}, 32'h0000_0200);
      pulse_dirty_clr(4'b0100);
      wr(32'h640, 4'hF, 32'h0000_0002);
      check("ch2_enabled", {28'b0, enable}, 32'h4);
      wr_err(32'h64C, 4'hF, 32'hFFFF_FFF8);
      check("ndar2_locked_value", {3'b0, ndar[2*29 +: 29]}, 32'h0000_0200);
      check("ndar2_locked_dirty", {28'b0, ndar_dirty}, 32'h0);
      wr(32'h640, 4'hF, 32'h0000_0000);

      // Channel 0 CCR: all fields, int_clear pulse, append clear.
      wr(32'h600, 4'hF, 32'h4000_0007);
      check("ccr0_int_clear_pulse", {28'b0, int_clear}, 32'h1);
      check("ccr0_enable", {28'b0, enable}, 32'h1);
      check("ccr0_append", {28'b0, append}, 32'h1);
      check("ccr0_int_enable", {28'b0, int_enable}, 32'h1);
      @(negedge clk);
      check("ccr0_int_clear_gone", {28'b0, int_clear}, 32'h0);
      rd(32'h600, 32'h4000_0003);
      @(negedge clk);
      append_clr = 4'b0001;
      @(negedge clk);
      append_clr = '0;
      check("append_cleared", {28'b0, append}, 32'h0);
      check("enable_kept", {28'b0, enable}, 32'h1);

      // Channel 3 status reads and reserved channel registers.
      rd(32'h664, 32'h0000_0002);
      rd(32'h668, 32'hDEAD_BEEF);
      rd(32'h670, 32'h00AB_CDEF);
      rd(32'h618, 32'h0000_0000);
      wr(32'h61C, 4'hF, 32'hFFFF_FFFF);

      // Pending / mask / irq timing, set-wins against W1C.
      wr(32'h408, 4'hF, 32'h0000_0002);
      @(negedge clk);
      ch_int[1] = 1'b1;
      @(negedge clk);
      check("irq_lags_pend", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rises", {31'b0, irq}, 32'd1);
      rd(32'h404, 32'h0000_0002);
      @(negedge clk);
      ch_int[1] = 1'b0;
      fork
         wr(32'h404, 4'hF, 32'h0000_0002);
         begin
            @(negedge clk);
            ch_int[1] = 1'b1;
         end
      join
      rd(32'h404, 32'h0000_0002);
      wr(32'h404, 4'hF, 32'h0000_0002);
      @(negedge clk);
      check("irq_after_w1c", {31'b0, irq}, 32'd0);
      rd(32'h404, 32'h0000_0000);

      // Illegal accesses: no state change.
      rd_err(32'h6A0);
      wr_err(32'h6A0, 4'hF, 32'hFFFF_FFFF);
      check("ch5_no_change", {28'b0, enable}, 32'h1);
      rd_err(32'h418);
      wr_err(32'h008, 4'hF, 32'hFFFF_FFFF);
      rd(32'h408, 32'h0000_0002);
      wr_err(32'h00C, 4'hF, 32'hFFFF_FFFF);
      check("alias_sysctl_ignored", {31'b0, sys_rst}, 32'd0);

      // SYSCTL byte lanes.
      wr(32'h40C, 4'h1, 32'hFFFF_FFFF);
      check("sysctl_lane0_only", {31'b0, sys_rst}, 32'd0);
      rd(32'h40C, 32'h0000_0000);
      wr(32'h40C, 4'h8, 32'h8000_0000);
      check("sysctl_lane3", {31'b0, sys_rst}, 32'd1);
      rd(32'h40C, 32'h8000_0000);
      wr(32'h40C, 4'hF, 32'h0000_0000);
      check("sysctl_cleared", {31'b0, sys_rst}, 32'd0);

      // Reset asserted during RESP, then writes arriving during reset.
      ch_int = '0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_adr_i = 32'h400;
      mon_e.err = 1'b0;
      mon_e.dat = 32'hAA55_0204;
      mon_e.chk = 1'b1;
      sb.push_back(mon_e);
      @(negedge clk);
      check("resp_before_rst", {31'b0, bus.wbs_ack_o}, 32'd1);
      rst_n         = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      @(negedge clk);
      check("rst_resp_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
      check("rst_resp_dat", bus.wbs_dat_o, 32'h0);
      check("rst_resp_enable", {28'b0, enable}, 32'h0);
      check("rst_resp_int_enable", {28'b0, int_enable}, 32'h0);
      check("rst_resp_sys_rst", {31'b0, sys_rst}, 32'd1);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b1;
      bus.wbs_sel_i = 4'hF;
      bus.wbs_adr_i = 32'h408;
      bus.wbs_dat_i = 32'h0000_000F;
      @(negedge clk);
      bus.wbs_adr_i = 32'h64C;
      bus.wbs_dat_i = 32'h8765_4320;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      rd(32'h408, 32'h0000_0000);
      check("ndar_kept_over_reset", {3'b0, ndar[2*29 +: 29]}, 32'h0000_0200);
      check("dirty_after_reset", {28'b0, ndar_dirty}, 32'h0);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
